// File: rtl/prog_counter.sv
// prog_counter: parametrised up/down counter with programmable modulus,
// wrap/saturate bound handling, clock prescaler, parallel load, a registered
// terminal-count pulse and a sticky overflow flag.
//
// Edge priority is rst > load > step. A step fires only when the prescaler
// reaches its terminal value while en is high and no load is present.
// The prescaler comparison is >= so that lowering prescale below the current
// phase fires a step immediately instead of running the phase all the way
// around.
//
// Outputs are registered, so there are no combinational paths from inputs to outputs.
module prog_counter #(
  parameter int WIDTH = 8,
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] mod_val,
  input  logic [PRE_W-1:0] prescale,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] ZERO_CNT = '0;
  localparam logic [WIDTH-1:0] ONE_CNT  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PRE_W-1:0] ZERO_PC  = '0;
  localparam logic [PRE_W-1:0] ONE_PC   = {{(PRE_W-1){1'b0}}, 1'b1};

  logic [PRE_W-1:0] pc;
  logic [PRE_W-1:0] pc_next;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] step_val;
  logic             pc_term;
  logic             step_fire;
  logic             at_upper;
  logic             at_lower;
  logic             bound;

  // Prescaler terminal detection and step qualification.
  always_comb begin
    pc_term   = (pc >= prescale);
    step_fire = en && !load && pc_term;
  end

  // Bound detection for the current direction.
  always_comb begin
    at_upper = (count >= mod_val);
    at_lower = (count == ZERO_CNT);
    bound    = step_fire && (dir ? at_lower : at_upper);
  end

  // Value the count takes if a step fires this edge.
  always_comb begin
    step_val = count;
    if (!dir) begin
      if (at_upper) begin
        step_val = sat ? count : ZERO_CNT;
      end else begin
        step_val = count + ONE_CNT;
      end
    end else begin
      if (at_lower) begin
        step_val = sat ? ZERO_CNT : mod_val;
      end else if (count > mod_val) begin
        // A count loaded above the modulus is pulled back into range first.
        step_val = mod_val;
      end else begin
        step_val = count - ONE_CNT;
      end
    end
  end

  // Next prescaler phase: cleared on load or on a firing step. It holds while disabled.
  always_comb begin
    pc_next = pc;
    if (load) begin
      pc_next = ZERO_PC;
    end else if (en) begin
      pc_next = pc_term ? ZERO_PC : (pc + ONE_PC);
    end
  end

  // Next count value: a load wins over a step.
  always_comb begin
    count_next = count;
    if (load) begin
      count_next = load_val;
    end else if (step_fire) begin
      count_next = step_val;
    end
  end

  // Count and prescaler state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= ZERO_CNT;
      pc    <= ZERO_PC;
    end else begin
      count <= count_next;
      pc    <= pc_next;
    end
  end

  // Terminal-count pulse. It is high for exactly the edge after a bound event.
  always_ff @(posedge clk) begin
    if (rst) begin
      tc <= 1'b0;
    end else begin
      tc <= bound;
    end
  end

  // Sticky overflow flag. A bound event on the same edge beats clr_ovf.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (bound) begin
      ovf <= 1'b1;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prog_counter.sv
// Directed testbench for prog_counter. Each task drives one scenario and
// compares the registered outputs against hand-computed values.
module tb_prog_counter;

  localparam int W = 8;
  localparam int P = 4;

  logic         clk;
  logic         rst;
  logic         en;
  logic         dir;
  logic         sat;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] mod_val;
  logic [P-1:0] prescale;
  logic         clr_ovf;
  logic [W-1:0] count;
  logic         tc;
  logic         ovf;

  int checks;
  int failures;

  prog_counter #(.WIDTH(W), .PRE_W(P)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .dir      (dir),
    .sat      (sat),
    .load     (load),
    .load_val (load_val),
    .mod_val  (mod_val),
    .prescale (prescale),
    .clr_ovf  (clr_ovf),
    .count    (count),
    .tc       (tc),
    .ovf      (ovf)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load     = 1'b1;
    load_val = v;
    tick();
    load     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; load = 1'b1; load_val = 8'h5A; clr_ovf = 1'b0;
    tick();
    tick();
    checks++;
    if (count !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++;
    if (tc !== 1'b0) begin failures++; $display("FAIL reset_tc got=%b exp=0", tc); end
    checks++;
    if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    rst = 1'b0; load = 1'b0; en = 1'b0;
  endtask

  task automatic test_up_count();
    int exp_cnt;
    int tc_seen;
    int tc_ok;
    en = 1'b1; dir = 1'b0; sat = 1'b0; mod_val = 8'd255; prescale = 4'd0;
    exp_cnt = 0;
    tc_seen = 0;
    tc_ok   = 1;
    for (int i = 0; i < 260; i++) begin
      tick();
      exp_cnt = (exp_cnt + 1) % 256;
      checks++;
      if (count !== exp_cnt[W-1:0]) begin
        failures++; $display("FAIL up_count step=%0d got=%0d exp=%0d", i, count, exp_cnt);
      end
      checks++;
      if (tc !== (i == 255)) begin
        failures++; $display("FAIL up_tc step=%0d got=%b exp=%b", i, tc, (i == 255));
      end
    end
    checks++;
    if (ovf !== 1'b1) begin failures++; $display("FAIL up_ovf got=%b exp=1", ovf); end
    en = 1'b0; clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin failures++; $display("FAIL up_clr_ovf got=%b exp=0", ovf); end
  endtask

  task automatic test_mod_down();
    logic [W-1:0] exp_c [5];
    logic         exp_t [5];
    exp_c = '{8'd1, 8'd0, 8'd9, 8'd8, 8'd7};
    exp_t = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    mod_val = 8'd9; dir = 1'b1; sat = 1'b0; prescale = 4'd0; en = 1'b1;
    do_load(8'd2);
    checks++;
    if (count !== 8'd2 || tc !== 1'b0) begin
      failures++; $display("FAIL down_load got=%0d/%b exp=2/0", count, tc);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (count !== exp_c[i] || tc !== exp_t[i]) begin
        failures++;
        $display("FAIL down_wrap step=%0d got=%0d/%b exp=%0d/%b", i, count, tc, exp_c[i], exp_t[i]);
      end
    end
    // A loaded value above the modulus is pulled back to the modulus on a down step.
    do_load(8'd12);
    tick();
    checks++;
    if (count !== 8'd9 || tc !== 1'b0) begin
      failures++; $display("FAIL down_above_mod got=%0d/%b exp=9/0", count, tc);
    end
    en = 1'b0;
  endtask

  task automatic test_saturate();
    logic [W-1:0] exp_c [7];
    logic         exp_t [7];
    sat = 1'b1; dir = 1'b0; mod_val = 8'd5; prescale = 4'd0; en = 1'b1;
    do_load(8'd0);
    exp_c = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd5, 8'd5};
    exp_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if (count !== exp_c[i] || tc !== exp_t[i]) begin
        failures++;
        $display("FAIL sat_up step=%0d got=%0d/%b exp=%0d/%b", i, count, tc, exp_c[i], exp_t[i]);
      end
    end
    dir = 1'b1;
    exp_c = '{8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0};
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if (count !== exp_c[i] || tc !== exp_t[i]) begin
        failures++;
        $display("FAIL sat_down step=%0d got=%0d/%b exp=%0d/%b", i, count, tc, exp_c[i], exp_t[i]);
      end
    end
    // A modulus of zero pins the count at zero and makes every step a bound event.
    sat = 1'b0; dir = 1'b0; mod_val = 8'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (count !== 8'd0 || tc !== 1'b1) begin
        failures++; $display("FAIL mod_zero step=%0d got=%0d/%b exp=0/1", i, count, tc);
      end
    end
    en = 1'b0;
    tick();
    checks++;
    if (tc !== 1'b0) begin failures++; $display("FAIL tc_disabled got=%b exp=0", tc); end
  endtask

  task automatic test_prescaler();
    int exp_cnt;
    sat = 1'b0; dir = 1'b0; mod_val = 8'd255; prescale = 4'd3; en = 1'b1;
    do_load(8'd0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp_cnt = k / 4;
      checks++;
      if (count !== exp_cnt[W-1:0] || tc !== 1'b0) begin
        failures++; $display("FAIL presc_run k=%0d got=%0d/%b exp=%0d/0", k, count, tc, exp_cnt);
      end
    end
    // Phase is now 2 with the count at 2. Disable for 5 cycles.
    en = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    checks++;
    if (count !== 8'd2) begin failures++; $display("FAIL presc_hold got=%0d exp=2", count); end
    en = 1'b1;
    tick();
    checks++;
    if (count !== 8'd2) begin failures++; $display("FAIL presc_resume1 got=%0d exp=2", count); end
    tick();
    checks++;
    if (count !== 8'd3) begin failures++; $display("FAIL presc_resume2 got=%0d exp=3", count); end
    // Shrinking prescale below the current phase fires a step at once.
    do_load(8'd0);
    for (int k = 0; k < 3; k++) tick();
    prescale = 4'd1;
    tick();
    checks++;
    if (count !== 8'd1) begin failures++; $display("FAIL presc_shrink got=%0d exp=1", count); end
    en = 1'b0; prescale = 4'd0;
  endtask

  task automatic test_simultaneous();
    prescale = 4'd0; mod_val = 8'd9; dir = 1'b0; sat = 1'b0; en = 1'b1;
    // A load coincides with a step that would otherwise fire.
    do_load(8'h42);
    checks++;
    if (count !== 8'h42 || tc !== 1'b0) begin
      failures++; $display("FAIL load_vs_step got=%0h/%b exp=42/0", count, tc);
    end
    en = 1'b0; clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    do_load(8'd9);
    en = 1'b1; clr_ovf = 1'b1;
    tick();
    checks++;
    if (count !== 8'd0 || tc !== 1'b1 || ovf !== 1'b1) begin
      failures++; $display("FAIL bound_vs_clr got=%0d/%b/%b exp=0/1/1", count, tc, ovf);
    end
    en = 1'b0;
    tick();
    clr_ovf = 1'b0;
    checks++;
    if (ovf !== 1'b0 || tc !== 1'b0) begin
      failures++; $display("FAIL clr_alone got=%b/%b exp=0/0", ovf, tc);
    end
  endtask

  task automatic test_reset_priority();
    mod_val = 8'd255; dir = 1'b1; sat = 1'b0; prescale = 4'd0; en = 1'b1;
    do_load(8'd0);
    tick();
    checks++;
    if (count !== 8'd255 || ovf !== 1'b1) begin
      failures++; $display("FAIL rp_setup got=%0d/%b exp=255/1", count, ovf);
    end
    do_load(8'h37);
    rst = 1'b1; load = 1'b1; load_val = 8'hAA;
    tick();
    rst = 1'b0; load = 1'b0; en = 1'b0;
    checks++;
    if (count !== 8'd0 || tc !== 1'b0 || ovf !== 1'b0) begin
      failures++; $display("FAIL rst_priority got=%0h/%b/%b exp=0/0/0", count, tc, ovf);
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; en = 1'b0; dir = 1'b0; sat = 1'b0; load = 1'b0;
    load_val = '0; mod_val = 8'd255; prescale = '0; clr_ovf = 1'b0;
    test_reset();
    test_up_count();
    test_mod_down();
    test_saturate();
    test_prescaler();
    test_simultaneous();
    test_reset_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_counter.md
# prog_counter

Parametrised synchronous counter that generalises the team's fixed 8-bit free-running counter. It supports configurable width, up/down direction, a programmable modulus, wrap or saturate at the bounds, a programmable clock prescaler, parallel load, a registered terminal-count pulse and a sticky overflow flag. It sits behind the tile's dedicated I/O wrapper, which maps its controls onto `ui_in`/`uio_in` and its count onto `uo_out`. It is also intended as a reusable timer/divider primitive inside larger designs.

## Interface
- `WIDTH`, default 8: counter width in bits; must be at least 2.
- `PRE_W`, default 4: prescaler width in bits.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  count enable; gates both the prescaler and the counter.
- `dir`  in  1  0 = count up, 1 = count down.
- `sat`  in  1  0 = wrap at the bounds, 1 = saturate (hold) at the bounds.
- `load`  in  1  parallel load strobe.
- `load_val`  in  WIDTH  value written to the count on `load`.
- `mod_val`  in  WIDTH  upper bound; the count range is 0..`mod_val`.
- `prescale`  in  PRE_W  the counter steps once every `prescale`+1 enabled cycles.
- `clr_ovf`  in  1  clears `ovf`.
- `count`  out  WIDTH  current count.
- `tc`  out  1  terminal-count pulse, one cycle per bound event.
- `ovf`  out  1  sticky bound-event flag.

## Operation
- **State:** `count` register, prescaler register `pc` (PRE_W bits), `tc` register, `ovf` register.
- **Per-edge priority:** `rst` > `load` > step.
- **Reset:** `count`=0, `pc`=0, `tc`=0, `ovf`=0.
- **Load:**
  - `count`<=`load_val` and `pc`<=0.
  - `tc` is 0 in the following cycle.
  - `ovf` is unaffected, apart from the `clr_ovf` rule.
  - `load_val` may exceed `mod_val`; it is loaded verbatim.
- **Prescaler:**
  - With `en`=1 and no load: if `pc`==`prescale`, a step fires and `pc`<=0; otherwise `pc`<=`pc`+1 and no step fires.
  - With `en`=0, `pc` and `count` hold.
  - If `prescale` is changed while `pc`>`prescale`, the comparison uses `>=`. A step fires and `pc`<=0.
- **Step, up (`dir`=0):**
  - If `count`>=`mod_val`, this is a bound event. `count`<=0 when `sat`=0, or holds when `sat`=1.
  - Otherwise `count`<=`count`+1.
- **Step, down (`dir`=1):**
  - If `count`==0, this is a bound event. `count`<=`mod_val` when `sat`=0, or holds at 0 when `sat`=1.
  - Otherwise, if `count`>`mod_val`, `count`<=`mod_val`.
  - Otherwise `count`<=`count`-1.
- **Bound event effects:** `tc`<=1 and `ovf`<=1. On every other edge `tc`<=0.
- **`clr_ovf`:** `ovf`<=0, unless a bound event occurs on the same edge, in which case set wins. `rst` clears `ovf` regardless.
- **Sampling:** `mod_val`, `dir` and `sat` are sampled at each step; no shadow registers. A mid-count change of any of them takes effect at the next step.
- **`mod_val`==0:** the count stays at 0. Every step is a bound event, so `tc` pulses on every step.
- **Arithmetic:** WIDTH bits, no extension. With `mod_val` = 2^WIDTH-1 the block behaves as a plain binary counter.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- **Step latency:** an edge with a firing step updates `count` on that edge, so the new value is visible in the next cycle. `tc` is high in the same cycle that the wrapped (or held) value is visible.
- **Load latency:** `load` sampled at edge N gives `count`==`load_val` in cycle N+1.
- **Step period:** with `en` held high, steps fire every `prescale`+1 cycles. The first step occurs `prescale`+1 edges after reset or load.
- **Reset mid-operation:** takes effect on the next edge regardless of `load`/`en`. Outputs read reset values in the following cycle.
- **`tc` width:** exactly one cycle per bound event. It is never stretched by `en`=0 or by the prescaler.

## Test plan
- **Reset and up count:** reset, then `en`=1, `dir`=0, `sat`=0, `mod_val`=255, `prescale`=0 for 260 cycles. Required: `count` is 0,1,…,255,0,1,…; `tc` pulses exactly once, in the cycle showing 0 after 255; `ovf`=1 after that.
- **Modulus, down, wrap:** `mod_val`=9, `dir`=1, `load_val`=2 with `load` pulsed, then `en`=1. Required: `count` is 2,1,0,9,8,…; `tc` is high with the first 9.
- **Saturate:** `sat`=1, `dir`=0, `mod_val`=5, count from 0. Required: `count` sticks at 5; `tc` pulses on every step attempt at 5. Then switch to `dir`=1 and step down to 0. Required: `count` holds at 0 and `tc` pulses on each step attempt there.
- **Prescaler:** `prescale`=3, `mod_val`=255, count up from 0. Required: `count` increments every 4 cycles. Drop `en` for 5 cycles mid-period. Required: `count` and the phase hold, and the step resumes after the remaining enabled cycles.
- **Simultaneous events:** `load` and a firing step on the same edge give `count`=`load_val`. A bound event and `clr_ovf` on the same edge give `ovf`=1. Then `clr_ovf` alone gives `ovf`=0.
- **Reset priority:** assert `rst` together with `load`=1, `load_val`=0xAA while `count`=0x37. Required: next cycle shows `count`=0, `tc`=0, `ovf`=0.
